// File: rtl/data_unpacker.sv
// data_unpacker: splits words of up to LANES packed bytes into one byte per beat, tlast preserved.
// Lane 0 is valid one cycle after accept. Optional UNPACK_MSB_FIRST_EN emits lanes high-to-low.
module data_unpacker #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   localparam int KW        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [KW-1:0]               k,
   input  logic [DATA_WIDTH*LANES-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic                        s_axis_tlast,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [15:0]                 pkt_count
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                      state, state_nxt;
   logic [DATA_WIDTH*LANES-1:0] buf_word;
   logic                        buf_last;
   logic                        sop;
   logic [KW-1:0]               lane_idx;
   logic [KW-1:0]               lanes_r;
   logic [KW-1:0]               lane_sel;
   logic [DATA_WIDTH-1:0]       lane_dat [LANES];
   logic                        last_byte;
   logic                        pop;
   logic                        accept;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_dat[i] = buf_word[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign last_byte = (lane_idx == lanes_r);
   assign pop       = m_axis_tvalid & m_axis_tready;
   assign accept    = s_axis_tvalid & s_axis_tready;

   // lane_idx always counts up; only the lane it selects is mirrored
`ifdef UNPACK_MSB_FIRST_EN
   assign lane_sel = lanes_r - lane_idx;
`else
   assign lane_sel = lane_idx;
`endif

   assign m_axis_tdata = lane_dat[lane_sel];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state)
         IDLE: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) state_nxt = SHIFT;
         end
         SHIFT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = buf_last & last_byte;
            // Ready on the final pop lets the next word load with no bubble
            s_axis_tready = m_axis_tready & last_byte;
            if (m_axis_tready & last_byte & ~s_axis_tvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_word  <= '0;
         buf_last  <= 1'b0;
         lane_idx  <= '0;
         lanes_r   <= '0;
         sop       <= 1'b1;
         pkt_count <= 16'd0;
      end else begin
         if (accept) begin
            buf_word <= s_axis_tdata;
            buf_last <= s_axis_tlast;
            lane_idx <= '0;
            sop      <= s_axis_tlast;
            // Lane count is fixed for the whole packet
            if (sop) lanes_r <= k;
         end else if (pop) begin
            if (last_byte) lane_idx <= '0;
            else           lane_idx <= lane_idx + KW'(1);
         end
         if (pop & m_axis_tlast) pkt_count <= pkt_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker; expectations follow UNPACK_MSB_FIRST_EN when defined.
module tb_data_unpacker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  k = '0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;
   logic [15:0] pkt_count;

   int vectors = 0;
   int miscompares = 0;

   data_unpacker #(.DATA_WIDTH(8), .LANES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .k            (k),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tlast (m_tlast),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
      vectors++; if (m_tdata !== 8'h00) begin miscompares++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
      vectors++; if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
      reset = 1'b0;
      #1;
      vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_s_tready: got %b want 1", s_tready); end
   endtask

   task automatic test_basic_k3();
      logic [7:0] e [4];
`ifdef UNPACK_MSB_FIRST_EN
      e = '{8'h44, 8'h33, 8'h22, 8'h11};
`else
      e = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
      k = 2'd3; s_tdata = 32'h44332211; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      #1;
      vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL k3_idle_ready: got %b want 1", s_tready); end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL k3_tvalid[%0d]: got %b want 1", i, m_tvalid); end
         vectors++; if (m_tdata !== e[i]) begin miscompares++; $display("FAIL k3_tdata[%0d]: got %h want %h", i, m_tdata, e[i]); end
         vectors++; if (m_tlast !== (i == 3)) begin miscompares++; $display("FAIL k3_tlast[%0d]: got %b want %b", i, m_tlast, (i == 3)); end
         tick();
      end
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL k3_idle_after: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd1) begin miscompares++; $display("FAIL k3_pkt_count: got %0d want 1", pkt_count); end
   endtask

   task automatic test_back_to_back_k1();
      logic [7:0] e [4];
      logic       r [4];
`ifdef UNPACK_MSB_FIRST_EN
      e = '{8'hBB, 8'hAA, 8'hDD, 8'hCC};
`else
      e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif
      r = '{1'b0, 1'b1, 1'b0, 1'b1};
      k = 2'd1; s_tdata = 32'h5A5ABBAA; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
      tick();
      s_tdata = 32'hA5A5DDCC; s_tlast = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL k1_tvalid[%0d]: got %b want 1", i, m_tvalid); end
         vectors++; if (m_tdata !== e[i]) begin miscompares++; $display("FAIL k1_tdata[%0d]: got %h want %h", i, m_tdata, e[i]); end
         vectors++; if (m_tlast !== (i == 3)) begin miscompares++; $display("FAIL k1_tlast[%0d]: got %b want %b", i, m_tlast, (i == 3)); end
         vectors++; if (s_tready !== r[i]) begin miscompares++; $display("FAIL k1_s_tready[%0d]: got %b want %b", i, s_tready, r[i]); end
         tick();
         if (i == 1) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      end
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL k1_idle_after: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd2) begin miscompares++; $display("FAIL k1_pkt_count: got %0d want 2", pkt_count); end
   endtask

   task automatic test_stall();
      logic [7:0] e [4];
      int idx = 0;
`ifdef UNPACK_MSB_FIRST_EN
      e = '{8'hA4, 8'hA3, 8'hA2, 8'hA1};
`else
      e = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
`endif
      k = 2'd3; s_tdata = 32'hA4A3A2A1; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int c = 0; c < 7; c++) begin
         m_tready = (c % 2 == 0);
         #1;
         vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL stall_tvalid[%0d]: got %b want 1", c, m_tvalid); end
         vectors++; if (m_tdata !== e[idx]) begin miscompares++; $display("FAIL stall_tdata[%0d]: got %h want %h", c, m_tdata, e[idx]); end
         vectors++; if (m_tlast !== (idx == 3)) begin miscompares++; $display("FAIL stall_tlast[%0d]: got %b want %b", c, m_tlast, (idx == 3)); end
         vectors++; if (s_tready !== (m_tready && idx == 3)) begin miscompares++; $display("FAIL stall_s_tready[%0d]: got %b want %b", c, s_tready, (m_tready && idx == 3)); end
         tick();
         if (c % 2 == 0) idx++;
      end
      m_tready = 1'b1;
      #1;
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL stall_idle_after: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd3) begin miscompares++; $display("FAIL stall_pkt_count: got %0d want 3", pkt_count); end
   endtask

   task automatic test_k_change();
      logic [31:0] w [4];
      logic [1:0]  kk [4];
      logic        ll [4];
      logic [7:0]  e [10];
      logic        el [10];
      int widx = 0;
      int bidx = 0;
      int cyc = 0;
      logic acc;
      w  = '{32'h14131211, 32'h24232221, 32'hFFFFFFB1, 32'hFFFFFFB2};
      kk = '{2'd3, 2'd0, 2'd0, 2'd0};
      ll = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef UNPACK_MSB_FIRST_EN
      e = '{8'h14, 8'h13, 8'h12, 8'h11, 8'h24, 8'h23, 8'h22, 8'h21, 8'hB1, 8'hB2};
`else
      e = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24, 8'hB1, 8'hB2};
`endif
      el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      m_tready = 1'b1;
      while (bidx < 10 && cyc < 40) begin
         s_tvalid = (widx < 4);
         if (widx < 4) begin s_tdata = w[widx]; k = kk[widx]; s_tlast = ll[widx]; end
         #1;
         if (m_tvalid) begin
            vectors++; if (m_tdata !== e[bidx]) begin miscompares++; $display("FAIL kchg_tdata[%0d]: got %h want %h", bidx, m_tdata, e[bidx]); end
            vectors++; if (m_tlast !== el[bidx]) begin miscompares++; $display("FAIL kchg_tlast[%0d]: got %b want %b", bidx, m_tlast, el[bidx]); end
            bidx++;
         end
         acc = s_tvalid && s_tready;
         tick();
         if (acc) widx++;
         cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      vectors++; if (bidx !== 10) begin miscompares++; $display("FAIL kchg_timeout: got %0d bytes want 10", bidx); end
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL kchg_extra_byte: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd5) begin miscompares++; $display("FAIL kchg_pkt_count: got %0d want 5", pkt_count); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] c [2];
      logic [7:0] d [2];
`ifdef UNPACK_MSB_FIRST_EN
      c = '{8'hC4, 8'hC3};
      d = '{8'hD2, 8'hD1};
`else
      c = '{8'hC1, 8'hC2};
      d = '{8'hD1, 8'hD2};
`endif
      k = 2'd3; s_tdata = 32'hC4C3C2C1; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vectors++; if (m_tdata !== c[i]) begin miscompares++; $display("FAIL rmid_tdata[%0d]: got %h want %h", i, m_tdata, c[i]); end
         tick();
      end
      reset = 1'b1;
      #1;
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL rmid_pkt_count: got %0d want 0", pkt_count); end
      tick();
      reset = 1'b0;
      k = 2'd1; s_tdata = 32'h0000D2D1; s_tlast = 1'b1; s_tvalid = 1'b1;
      #1;
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rmid_tvalid_after: got %b want 0", m_tvalid); end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vectors++; if (m_tdata !== d[i]) begin miscompares++; $display("FAIL rmid_new_tdata[%0d]: got %h want %h", i, m_tdata, d[i]); end
         vectors++; if (m_tlast !== (i == 1)) begin miscompares++; $display("FAIL rmid_new_tlast[%0d]: got %b want %b", i, m_tlast, (i == 1)); end
         tick();
      end
      vectors++; if (pkt_count !== 16'd1) begin miscompares++; $display("FAIL rmid_new_pkt_count: got %0d want 1", pkt_count); end
   endtask

   task automatic test_k0_follow();
      logic [31:0] w [3];
      logic        r [5];
      logic [7:0]  e [3];
      int widx = 1;
      int bidx = 0;
      logic acc;
      w = '{32'h000000E1, 32'h000000E2, 32'h000000E3};
      r = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      e = '{8'hE1, 8'hE2, 8'hE3};
      k = 2'd0; s_tdata = w[0]; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         s_tvalid = (widx < 3);
         if (widx < 3) begin s_tdata = w[widx]; s_tlast = (widx == 2); end
         m_tready = r[c];
         #1;
         vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL k0_tvalid[%0d]: got %b want 1", c, m_tvalid); end
         vectors++; if (s_tready !== r[c]) begin miscompares++; $display("FAIL k0_s_tready[%0d]: got %b want %b", c, s_tready, r[c]); end
         vectors++; if (m_tdata !== e[bidx]) begin miscompares++; $display("FAIL k0_tdata[%0d]: got %h want %h", c, m_tdata, e[bidx]); end
         vectors++; if (m_tlast !== (bidx == 2)) begin miscompares++; $display("FAIL k0_tlast[%0d]: got %b want %b", c, m_tlast, (bidx == 2)); end
         acc = s_tvalid && s_tready;
         tick();
         if (r[c]) bidx++;
         if (acc) widx++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL k0_idle_after: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd2) begin miscompares++; $display("FAIL k0_pkt_count: got %0d want 2", pkt_count); end
   endtask

   task automatic test_k2_order();
      logic [7:0] e [3];
`ifdef UNPACK_MSB_FIRST_EN
      e = '{8'hCC, 8'hBB, 8'hAA};
`else
      e = '{8'hAA, 8'hBB, 8'hCC};
`endif
      k = 2'd2; s_tdata = 32'h00CCBBAA; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (m_tdata !== e[i]) begin miscompares++; $display("FAIL k2_tdata[%0d]: got %h want %h", i, m_tdata, e[i]); end
         vectors++; if (m_tlast !== (i == 2)) begin miscompares++; $display("FAIL k2_tlast[%0d]: got %b want %b", i, m_tlast, (i == 2)); end
         tick();
      end
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL k2_unused_lane: got %b want 0", m_tvalid); end
      vectors++; if (pkt_count !== 16'd3) begin miscompares++; $display("FAIL k2_pkt_count: got %0d want 3", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_basic_k3();
      test_back_to_back_k1();
      test_stall();
      test_k_change();
      test_reset_mid();
      test_k0_follow();
      test_k2_order();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
